// File: rtl/data_ram_if.sv
// data_ram_if: AXI4-Lite bus bundle (32-bit address and data) used by the data_ram slave.
//   master modport: drives aw*/w*/ar* requests and bready/rready, receives ready/response signals.
//   slave modport : receives requests, drives awready/wready/arready, b* and r* responses.
interface axi;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/data_ram.sv
// data_ram: AXI4-Lite slave word memory with byte strobes and independent read/write engines.
//   clk    : system clock, all state on the rising edge
//   resetn : asynchronous active-low reset (memory contents are not reset)
//   bus    : axi.slave, region-relative byte addresses, 32-bit data
// Optional: define DATA_RAM_BOUNDS_EN to answer SLVERR for addresses with bits set at or
// above ADDR_WIDTH (write suppressed, read data 0); otherwise such addresses wrap.
module data_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter     INIT_FILE  = ""
) (
    input logic clk,
    input logic resetn,
    axi.slave   bus
);
    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} rstate_t;

    logic [31:0] mem [0:DEPTH-1];

    wstate_t     wstate;
    rstate_t     rstate;
    logic        aw_done, w_done, aw_oob, ar_oob;
    logic [IW-1:0] aw_idx, ar_idx, we_idx;
    logic [31:0] w_data, we_data;
    logic [3:0]  w_strb, we_strb;
    logic        aw_hs, w_hs, ar_hs, do_write, ram_we;
    logic        aw_oob_in, ar_oob_in, we_oob;
    logic        unused_ok;

`ifdef DATA_RAM_BOUNDS_EN
    assign aw_oob_in = |bus.awaddr[31:ADDR_WIDTH];
    assign ar_oob_in = |bus.araddr[31:ADDR_WIDTH];
`else
    assign aw_oob_in = 1'b0;
    assign ar_oob_in = 1'b0;
`endif

    assign unused_ok = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0],
                         bus.awaddr[31:ADDR_WIDTH], bus.araddr[31:ADDR_WIDTH]};

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;

    assign we_idx  = aw_done ? aw_idx : bus.awaddr[ADDR_WIDTH-1:2];
    assign we_oob  = aw_done ? aw_oob : aw_oob_in;
    assign we_data = w_done ? w_data : bus.wdata;
    assign we_strb = w_done ? w_strb : bus.wstrb;

    assign do_write = (wstate == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
    assign ram_we   = do_write && !we_oob && resetn;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we && we_strb[i]) mem[we_idx][8*i +: 8] <= we_data[8*i +: 8];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate      <= W_IDLE;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            aw_oob      <= 1'b0;
            aw_idx      <= '0;
            w_data      <= '0;
            w_strb      <= '0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        bus.awready <= 1'b0;
                        aw_done     <= 1'b1;
                        aw_idx      <= bus.awaddr[ADDR_WIDTH-1:2];
                        aw_oob      <= aw_oob_in;
                    end
                    if (w_hs) begin
                        bus.wready <= 1'b0;
                        w_done     <= 1'b1;
                        w_data     <= bus.wdata;
                        w_strb     <= bus.wstrb;
                    end
                    if (do_write) begin
                        wstate     <= W_RESP;
                        bus.bvalid <= 1'b1;
                        bus.bresp  <= we_oob ? 2'b10 : 2'b00;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        wstate      <= W_IDLE;
                        bus.bvalid  <= 1'b0;
                        bus.awready <= 1'b1;
                        bus.wready  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate      <= R_IDLE;
            bus.arready <= 1'b1;
            bus.rvalid  <= 1'b0;
            bus.rresp   <= 2'b00;
            bus.rdata   <= '0;
            ar_idx      <= '0;
            ar_oob      <= 1'b0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate      <= R_READ;
                        bus.arready <= 1'b0;
                        ar_idx      <= bus.araddr[ADDR_WIDTH-1:2];
                        ar_oob      <= ar_oob_in;
                    end
                end
                R_READ: begin
                    rstate     <= R_RESP;
                    bus.rvalid <= 1'b1;
                    bus.rdata  <= ar_oob ? 32'h0 : mem[ar_idx];
                    bus.rresp  <= ar_oob ? 2'b10 : 2'b00;
                end
                R_RESP: begin
                    if (bus.rready) begin
                        rstate      <= R_IDLE;
                        bus.rvalid  <= 1'b0;
                        bus.arready <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: table-driven and hand-sequenced checks of the data_ram AXI4-Lite memory.
module tb_data_ram;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   applied = 0;
    int   miscompares = 0;

`ifdef DATA_RAM_BOUNDS_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    axi bus();

    data_ram #(.ADDR_WIDTH(12)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic ok);
        logic aw_go, w_go, aw_f, w_f;
        int n;
        aw_go = 1'b1; w_go = 1'b1; n = 0; ok = 1'b0; resp = 2'bxx;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        while ((aw_go || w_go) && n < 50) begin
            @(negedge clk);
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_f) begin bus.awvalid = 1'b0; aw_go = 1'b0; end
            if (w_f)  begin bus.wvalid = 1'b0;  w_go = 1'b0;  end
            n++;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bus.bvalid) begin ok = 1'b1; resp = bus.bresp; end
            @(posedge clk); #1;
            n++;
        end
        bus.bready = 1'b0;
        ok = ok && !aw_go && !w_go;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output logic ok);
        logic go, f;
        int n;
        go = 1'b1; n = 0; ok = 1'b0; d = 'x; resp = 2'bxx;
        bus.araddr = a; bus.arvalid = 1'b1;
        while (go && n < 50) begin
            @(negedge clk);
            f = bus.arready;
            @(posedge clk); #1;
            if (f) begin bus.arvalid = 1'b0; go = 1'b0; end
            n++;
        end
        bus.arvalid = 1'b0;
        bus.rready = 1'b1; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bus.rvalid) begin ok = 1'b1; d = bus.rdata; resp = bus.rresp; end
            @(posedge clk); #1;
            n++;
        end
        bus.rready = 1'b0;
        ok = ok && !go;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;

        tbl[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00};
        tbl[1]  = '{1'b0, 32'h010, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
        tbl[2]  = '{1'b1, 32'h020, 32'h11223344, 4'hF, 32'h0, 2'b00};
        tbl[3]  = '{1'b1, 32'h020, 32'hAABBCCDD, 4'h5, 32'h0, 2'b00};
        tbl[4]  = '{1'b0, 32'h020, 32'h0, 4'h0, 32'h11BB33DD, 2'b00};
        tbl[5]  = '{1'b1, 32'h024, 32'h01020304, 4'hF, 32'h0, 2'b00};
        tbl[6]  = '{1'b1, 32'h024, 32'hCAFEF00D, 4'h0, 32'h0, 2'b00};
        tbl[7]  = '{1'b0, 32'h024, 32'h0, 4'h0, 32'h01020304, 2'b00};
        tbl[8]  = '{1'b0, 32'h013, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
        tbl[9]  = '{1'b1, 32'h040, 32'h0, 4'hF, 32'h0, 2'b00};
        tbl[10] = '{1'b1, 32'h004, 32'h12345678, 4'hF, 32'h0, 2'b00};
        tbl[11] = '{1'b1, 32'h1004, 32'h99999999, 4'hF, 32'h0, BE ? 2'b10 : 2'b00};
        tbl[12] = '{1'b0, 32'h004, 32'h0, 4'h0, BE ? 32'h12345678 : 32'h99999999, 2'b00};
        tbl[13] = '{1'b0, 32'h1004, 32'h0, 4'h0, BE ? 32'h0 : 32'h99999999, BE ? 2'b10 : 2'b00};
        tbl[14] = '{1'b1, 32'hFFC, 32'h0F0F0F0F, 4'hF, 32'h0, 2'b00};
        tbl[15] = '{1'b0, 32'hFFC, 32'h0, 4'h0, 32'h0F0F0F0F, 2'b00};

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h7);
        chk("rst_valid", {30'b0, bus.bvalid, bus.rvalid}, 32'h0);
        chk("rst_resp", {28'b0, bus.bresp, bus.rresp}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].is_wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r, ok);
                chk($sformatf("vec%0d_done", i), {31'b0, ok}, 32'h1);
                chk($sformatf("vec%0d_bresp", i), {30'b0, r}, {30'b0, tbl[i].exp_resp});
            end else begin
                do_read(tbl[i].addr, d, r, ok);
                chk($sformatf("vec%0d_done", i), {31'b0, ok}, 32'h1);
                chk($sformatf("vec%0d_rdata", i), d, tbl[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), {30'b0, r}, {30'b0, tbl[i].exp_resp});
            end
        end

        // Minimum write and read latency on word 0x30.
        bus.awaddr = 32'h30; bus.wdata = 32'hA1B2C3D4; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        chk("lat_w_ready", {30'b0, bus.awready, bus.wready}, 32'h3);
        chk("lat_w_nob", {31'b0, bus.bvalid}, 32'h0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        chk("lat_w_bvalid", {31'b0, bus.bvalid}, 32'h1);
        chk("lat_w_busy", {30'b0, bus.awready, bus.wready}, 32'h0);
        @(posedge clk); #1;
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        @(negedge clk);
        chk("lat_w_bdone", {29'b0, bus.bvalid, bus.awready, bus.wready}, 32'h3);
        @(posedge clk); #1;
        bus.araddr = 32'h30; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        chk("lat_r_n1", {30'b0, bus.rvalid, bus.arready}, 32'h0);
        @(negedge clk);
        chk("lat_r_n2", {31'b0, bus.rvalid}, 32'h1);
        chk("lat_r_data", bus.rdata, 32'hA1B2C3D4);
        @(posedge clk); #1;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        @(negedge clk);
        chk("lat_r_done", {30'b0, bus.rvalid, bus.arready}, 32'h1);
        @(posedge clk); #1;

        // W first, AW four cycles later, then a stalled B channel.
        bus.wdata = 32'h600DF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("dec_wait%0d", k), {29'b0, bus.wready, bus.bvalid, bus.awready}, 32'h1);
            @(posedge clk); #1;
        end
        bus.awaddr = 32'h60; bus.awvalid = 1'b1;
        @(negedge clk);
        chk("dec_aw_cycle", {30'b0, bus.awready, bus.wready}, 32'h2);
        @(posedge clk); #1;
        bus.awaddr = 32'h64;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("dec_hold%0d", k), {28'b0, bus.bvalid, bus.bresp, bus.awready}, 32'h8);
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0;
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        @(negedge clk);
        chk("dec_bdone", {30'b0, bus.bvalid, bus.awready}, 32'h1);
        @(posedge clk); #1;
        do_read(32'h60, d, r, ok);
        chk("dec_read", d, 32'h600DF00D);
        do_read(32'h64, d, r, ok);
        chk("dec_read64_ok", {31'b0, ok}, 32'h1);

        // Same-edge write and RAM read on word 0x40 (holds 0): read sees old data.
        bus.araddr = 32'h40; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.awaddr = 32'h40; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        @(negedge clk);
        chk("rbw_valids", {30'b0, bus.rvalid, bus.bvalid}, 32'h3);
        chk("rbw_rdata", bus.rdata, 32'h0);
        @(posedge clk); #1;
        bus.bready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("rbw_hold%0d", k), {bus.rdata[30:0], bus.rvalid}, 32'h1);
            @(posedge clk); #1;
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        do_read(32'h40, d, r, ok);
        chk("rbw_after", d, 32'h55);

        // Reset while AW is latched and W is still outstanding.
        do_write(32'h50, 32'hA5A5A5A5, 4'hF, r, ok);
        bus.awaddr = 32'h50; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        @(negedge clk);
        chk("rstw_pending", {30'b0, bus.awready, bus.wready}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("rstw_async", {29'b0, bus.awready, bus.wready, bus.bvalid}, 32'h6);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        do_write(32'h54, 32'h77, 4'hF, r, ok);
        chk("rstw_next_ok", {31'b0, ok}, 32'h1);
        do_read(32'h50, d, r, ok);
        chk("rstw_old", d, 32'hA5A5A5A5);
        do_read(32'h54, d, r, ok);
        chk("rstw_new", d, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
